// File: rtl/fir_coeff_loader_if.sv
//------------------------------------------------------------------------------
// fir_coeff_loader_if
// Coefficient write channel: valid/ready word stream with an end-of-set marker.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fir_coeff_loader_if #(
    parameter int COEFF_WIDTH = 16
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [COEFF_WIDTH-1:0] wr_data;
    logic                   wr_last;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/fir_coeff_loader.sv
//------------------------------------------------------------------------------
// fir_coeff_loader
// Double-buffered FIR coefficient loader: frames a word stream into a shadow
// bank and commits it atomically on a sample boundary.
// Option: FIR_COEFF_LOADER_RESET_IDENTITY_EN -> reset set is a unity pass-through.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_coeff_loader #(
    parameter int N           = 4,
    parameter int COEFF_WIDTH = 16,
    parameter int Q           = 14
) (
    input  wire                           clk,
    input  wire                           rst,
    fir_coeff_loader_if.slave             wr,
    input  wire                           abort,
    input  wire                           sample_en,
    output logic [COEFF_WIDTH*(N+1)-1:0]  packed_coeffs,
    output logic                          updated,
    output logic                          err,
    output logic                          busy
);

    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] c_N = IDX_W'(N);
    localparam logic [COEFF_WIDTH-1:0] c_UNITY = COEFF_WIDTH'(2 ** Q);

`ifdef FIR_COEFF_LOADER_RESET_IDENTITY_EN
    localparam bit c_IDENTITY_EN = 1'b1;
`else
    localparam bit c_IDENTITY_EN = 1'b0;
`endif

    localparam logic [COEFF_WIDTH*(N+1)-1:0] c_RESET_COEFFS =
        c_IDENTITY_EN ? {{(COEFF_WIDTH*N){1'b0}}, c_UNITY} : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                          r_state;
    logic [IDX_W-1:0]                r_index;
    logic [COEFF_WIDTH*(N+1)-1:0]    r_shadow;
    logic [COEFF_WIDTH*(N+1)-1:0]    r_packed;
    logic                            r_updated;
    logic                            r_err;
    logic                            r_busy;
    logic                            r_wr_ready;

    state_t                          w_next_state;
    logic [IDX_W-1:0]                w_next_index;
    logic                            w_accept;
    logic                            w_err;
    logic                            w_commit;
    logic                            w_shadow_we;

    assign w_accept      = wr.wr_valid & r_wr_ready;
    assign wr.wr_ready   = r_wr_ready;
    assign packed_coeffs = r_packed;
    assign updated       = r_updated;
    assign err           = r_err;
    assign busy          = r_busy;

    // Abort outranks every other event, including a same-cycle accept or commit.
    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_err        = 1'b0;
        w_commit     = 1'b0;
        w_shadow_we  = 1'b0;
        if (abort) begin
            w_next_state = S_IDLE;
            w_next_index = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_shadow_we = 1'b1;
                        if (wr.wr_last) begin
                            w_err = 1'b1;
                        end else begin
                            w_next_state = S_LOAD;
                            w_next_index = r_index + 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        w_shadow_we = 1'b1;
                        if (r_index == c_N) begin
                            if (wr.wr_last) begin
                                w_next_state = S_COMMIT;
                            end else begin
                                w_err        = 1'b1;
                                w_next_state = S_DRAIN;
                            end
                        end else if (wr.wr_last) begin
                            w_err        = 1'b1;
                            w_next_state = S_IDLE;
                            w_next_index = '0;
                        end else begin
                            w_next_index = r_index + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (sample_en) begin
                        w_commit     = 1'b1;
                        w_next_state = S_IDLE;
                        w_next_index = '0;
                    end
                end
                S_DRAIN: begin
                    if (w_accept && wr.wr_last) begin
                        w_next_state = S_IDLE;
                        w_next_index = '0;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_index = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_shadow   <= '0;
            r_packed   <= c_RESET_COEFFS;
            r_updated  <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_index    <= w_next_index;
            r_err      <= w_err;
            r_updated  <= w_commit;
            r_busy     <= (w_next_state != S_IDLE);
            r_wr_ready <= (w_next_state != S_COMMIT);
            if (w_shadow_we) begin
                r_shadow[COEFF_WIDTH*r_index +: COEFF_WIDTH] <= wr.wr_data;
            end
            if (w_commit) begin
                r_packed <= r_shadow;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 The block SHALL take parameter N, default 4, meaning filter order; N+1 coefficients per set, N>=1.
REQ-002 The block SHALL take parameter COEFF_WIDTH, default 16, meaning coefficient width in bits (signed two's complement).
REQ-003 The block SHALL take parameter Q, default 14, meaning coefficient scale index; unity gain is 2^Q.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_valid  input  1  write word offered.
REQ-007 wr_ready  output  1  loader can accept a word.
REQ-008 wr_data  input  COEFF_WIDTH  coefficient word, tap 0 first.
REQ-009 wr_last  input  1  marks final word of a set.
REQ-010 abort  input  1  discard any in-progress load.
REQ-011 sample_en  input  1  filter sample-boundary strobe; commits only occur here.
REQ-012 packed_coeffs  output  COEFF_WIDTH*(N+1)  active set; tap t at bits [COEFF_WIDTH*t +: COEFF_WIDTH], registered.
REQ-013 updated  output  1  one-cycle pulse after active set changes.
REQ-014 err  output  1  one-cycle pulse on framing error.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 A word SHALL be accepted on a rising edge where wr_valid and wr_ready are both 1; nothing else changes the shadow bank.
REQ-017 States SHALL be IDLE, LOAD, COMMIT, DRAIN; wr_ready = 1 in IDLE, LOAD, DRAIN; 0 in COMMIT.
REQ-018 Tap index counter SHALL be 0 in IDLE; the word accepted at index k goes to shadow slot k, and the index increments by 1 per accept.
REQ-019 IDLE->LOAD on accept with wr_last=0; index 0 with wr_last=1 is a framing error (err pulse, stay IDLE).
REQ-020 In LOAD, accept at index<N with wr_last=1: err pulse, shadow discarded, ->IDLE.
REQ-021 In LOAD, accept at index N with wr_last=1: ->COMMIT.
REQ-022 In LOAD, accept at index N with wr_last=0: err pulse, ->DRAIN.
REQ-023 DRAIN discards words until one with wr_last=1 is accepted, then ->IDLE; no further err pulses.
REQ-024 In COMMIT, on the first edge with sample_en=1, packed_coeffs SHALL load the shadow bank atomically, ->IDLE; updated pulses the following cycle.
REQ-025 sample_en in the same cycle as the final word accept SHALL NOT commit; earliest commit is the next sample_en while in COMMIT.
REQ-026 abort=1 in any state SHALL return to IDLE and clear the index, with no err and no commit; abort overrides a simultaneous accept or sample_en.
REQ-027 packed_coeffs SHALL change only on commit or reset; an errored or aborted load SHALL leave it untouched.
REQ-028 err and updated SHALL never both be 1 in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, index 0, shadow all 0, updated 0, err 0, busy 0, wr_ready 1 after release.
REQ-030 packed_coeffs reset value SHALL follow REQ-031; a load in progress at reset is discarded.

Configuration
REQ-031 Macro FIR_COEFF_LOADER_RESET_IDENTITY_EN: defined -> reset packed_coeffs tap 0 = 2^Q, other taps 0 (pass-through); undefined -> all taps 0.

Verification
REQ-032 Write 16'h4000,16'h0100,16'h0200,16'h0300,16'h0400 (last on fifth), then sample_en 3 cycles later -> packed_coeffs = {0400,0300,0200,0100,4000} on that edge, updated pulse next cycle, busy low.
REQ-033 Write 3 words with last on third -> err pulse, packed_coeffs unchanged, state IDLE, wr_ready 1.
REQ-034 Write 5 words without last, then 2 more with last on seventh -> one err pulse on fifth accept, busy until seventh accepted, no commit.
REQ-035 Full 5-word set, then abort asserted together with sample_en in COMMIT -> no update, no err, IDLE.
REQ-036 Assert rst mid-load after 2 words -> outputs reset asynchronously; packed_coeffs = 0 (macro undefined) or tap0=16'h4000 (macro defined).
